up_down_counter_mod: RTL and testbench
======================================

# up_down_counter_mod

Parametrised, modulus-programmable up/down counter with synchronous load, count enable, and wrap or saturate behaviour at the bounds. It is the general counting primitive for the design: timers, address sequencers and the modulo-N dividers instantiate it in place of fixed-width 3-bit counters. Over/underflow events are reported as registered single-cycle pulses so that counters can be cascaded.

## Interface
- WIDTH, 8: counter width in bits; minimum 1.
- MAX_VAL, 2**WIDTH-1: upper bound, so the counter range is 0..MAX_VAL (modulus MAX_VAL+1); must be less than 2**WIDTH.
- RST_VAL, 0: value loaded on reset; must be at most MAX_VAL.

- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; one step per cycle while high.
- up_down  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- sat_mode  in  1  1 saturates at the bounds, 0 wraps modulo MAX_VAL+1.
- count  out  WIDTH  current count, registered.
- ovf  out  1  registered pulse: an up-step was taken at MAX_VAL.
- unf  out  1  registered pulse: a down-step was taken at 0.
- at_bound  out  1  combinational: high when count==MAX_VAL with up_down=1, or count==0 with up_down=0.

## Operation
- Reset: while rst is high, count=RST_VAL, ovf=0, unf=0. This overrides everything, including mid-count and mid-load.
- Priority, evaluated each rising edge: load, then en, then hold.
- Load: count<=min(load_val, MAX_VAL). ovf and unf are 0 on that edge. en is ignored when load is high.
- Up step (en=1, up_down=1):
  - If count<MAX_VAL: count+1.
  - If count==MAX_VAL: count<=0 in wrap mode, or holds MAX_VAL in saturate mode. In both cases ovf<=1.
- Down step (en=1, up_down=0):
  - If count>0: count-1.
  - If count==0: count<=MAX_VAL in wrap mode, or holds 0 in saturate mode. In both cases unf<=1.
- Hold (en=0, load=0): count is unchanged, ovf=0, unf=0.
- Arithmetic: compare against MAX_VAL before incrementing. Never rely on natural 2**WIDTH overflow unless MAX_VAL=2**WIDTH-1.
- ovf and unf are never high in the same cycle.
- Changing direction or sat_mode takes effect on the next enabled edge. There is no state carry-over.

## Timing
- Latency: count, ovf and unf reflect inputs sampled at edge N immediately after edge N. ovf and unf last exactly one cycle unless the condition repeats, e.g. saturated with en held high, which gives a continuous high.
- at_bound has zero latency from count and up_down. It is intended for cascading: the higher stage's en is the lower stage's en AND at_bound.
- Reset assertion is asynchronous. Deassertion must be synchronised externally to clk.
- No handshake; all inputs are sampled every cycle.

## Configuration
- UDC_SAT_EN defined: saturate logic is compiled in, and sat_mode selects as described above.
- UDC_SAT_EN undefined: the sat_mode port remains present but is ignored. The counter always wraps. ovf and unf behave identically.

## Structure
- Package udc_pkg contains:
  - Direction constants UDC_DIR_UP=1'b1 and UDC_DIR_DOWN=1'b0.
  - Enum udc_step_e with values STEP_HOLD, STEP_LOAD, STEP_UP, STEP_DOWN, used for the priority decode.
- Sub-module udc_next_val is purely combinational. It takes count, the step type and sat_mode, and returns next count, ovf_next and unf_next. The top level holds only the registers and the at_bound logic.

## Test plan
All scenarios use WIDTH=3, MAX_VAL=5, RST_VAL=0 unless stated.
1. Reset mid-count: count at 3, raise rst between edges. count goes to 0 immediately (asynchronously), and ovf=unf=0.
2. Wrap up: en=1, up_down=1, sat_mode=0, start at 0, run 7 edges. Sequence is 1,2,3,4,5,0,1. ovf is high only after the 5→0 edge.
3. Saturate down (with UDC_SAT_EN): load 1, then en=1, up_down=0, sat_mode=1, run 3 edges. Sequence is 0,0,0 and unf is high on the 2nd and 3rd cycles. Without the macro the sequence is 0,5,4.
4. Load priority and clamp: en=1, up_down=1, load=1, load_val=7. count=5 (clamped) and ovf=0. On the next edge with load=0, count=0 and ovf=1.
5. Hold and at_bound: count=5 with en=0. count stays at 5 and ovf=0. at_bound=1 with up_down=1 and 0 with up_down=0.
6. Cascade: two instances chained through at_bound, 20 enabled cycles. The combined value equals 20 in mixed radix 6×6, i.e. high=3 and low=2.

Source files
------------

// File: rtl/udc_pkg.sv
// Shared types and constants for the up/down counter.
// Contents: direction constants and the per-edge step decode enum.
package udc_pkg;

  localparam logic UDC_DIR_UP   = 1'b1;
  localparam logic UDC_DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } udc_step_e;

endpackage : udc_pkg

// File: rtl/up_down_counter_mod_if.sv
// Control/status bundle of the up/down counter.
// master: drives en, up_down, load, load_val, sat_mode; observes count, ovf, unf, at_bound.
// slave : the counter itself.
interface up_down_counter_mod_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat_mode;
  logic [WIDTH-1:0] count;
  logic             ovf;
  logic             unf;
  logic             at_bound;

  modport master (
    output en, up_down, load, load_val, sat_mode,
    input  count, ovf, unf, at_bound
  );

  modport slave (
    input  en, up_down, load, load_val, sat_mode,
    output count, ovf, unf, at_bound
  );
endinterface : up_down_counter_mod_if

// File: rtl/udc_next_val.sv
// Combinational next-state function of the up/down counter.
// Ports: count_i (current), step_i (decoded action), sat_mode_i, load_val_i
//        -> count_next_o, ovf_next_o, unf_next_o.
// Configuration: UDC_SAT_EN compiles in saturation; otherwise sat_mode_i is ignored
// and the counter always wraps.
module udc_next_val
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count_i,
  input  udc_step_e        step_i,
  input  logic             sat_mode_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_next_o,
  output logic             ovf_next_o,
  output logic             unf_next_o
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic sat_active;

`ifdef UDC_SAT_EN
  assign sat_active = sat_mode_i;
`else
  logic unused_sat_mode;
  assign unused_sat_mode = sat_mode_i;
  assign sat_active      = 1'b0;
`endif

  // Bounds are compared before stepping so a non-power-of-two modulus wraps correctly.
  always_comb begin
    count_next_o = count_i;
    ovf_next_o   = 1'b0;
    unf_next_o   = 1'b0;
    case (step_i)
      STEP_LOAD: count_next_o = (load_val_i > MAX_W) ? MAX_W : load_val_i;
      STEP_UP: begin
        if (count_i == MAX_W) begin
          ovf_next_o   = 1'b1;
          count_next_o = sat_active ? MAX_W : '0;
        end else begin
          count_next_o = count_i + WIDTH'(1);
        end
      end
      STEP_DOWN: begin
        if (count_i == '0) begin
          unf_next_o   = 1'b1;
          count_next_o = sat_active ? '0 : MAX_W;
        end else begin
          count_next_o = count_i - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

endmodule : udc_next_val

// File: rtl/up_down_counter_mod.sv
// Modulus-programmable up/down counter with load, enable, wrap/saturate.
// Ports: clk, rst (async, active-high), bus (slave modport: en, up_down, load,
//        load_val, sat_mode in; count, ovf, unf registered out; at_bound combinational out).
// Configuration: UDC_SAT_EN enables saturate mode (see udc_next_val).
module up_down_counter_mod #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1,
  parameter int unsigned RST_VAL = 0
) (
  input logic                  clk,
  input logic                  rst,
  up_down_counter_mod_if.slave bus
);
  import udc_pkg::*;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  udc_step_e        step;

  // Priority decode: load, then enable, then hold.
  always_comb begin
    step = STEP_HOLD;
    if (bus.load) begin
      step = STEP_LOAD;
    end else if (bus.en) begin
      step = (bus.up_down == UDC_DIR_UP) ? STEP_UP : STEP_DOWN;
    end
  end

  udc_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count_i      (count_q),
    .step_i       (step),
    .sat_mode_i   (bus.sat_mode),
    .load_val_i   (bus.load_val),
    .count_next_o (count_d),
    .ovf_next_o   (ovf_d),
    .unf_next_o   (unf_d)
  );

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_W;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  // Zero-latency bound flag used to enable the next cascaded stage.
  assign bus.at_bound = (bus.up_down == UDC_DIR_UP) ? (count_q == MAX_W) : (count_q == '0);

endmodule : up_down_counter_mod

// File: tb/tb_up_down_counter_mod.sv
// Directed self-checking bench for up_down_counter_mod (WIDTH=3, MAX_VAL=5, RST_VAL=0).
module tb_up_down_counter_mod;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  up_down_counter_mod_if #(.WIDTH(3)) u  ();
  up_down_counter_mod_if #(.WIDTH(3)) c0 ();
  up_down_counter_mod_if #(.WIDTH(3)) c1 ();

  up_down_counter_mod #(.WIDTH(3), .MAX_VAL(5), .RST_VAL(0)) dut (
    .clk (clk), .rst (rst), .bus (u.slave)
  );
  up_down_counter_mod #(.WIDTH(3), .MAX_VAL(5), .RST_VAL(0)) dut_lo (
    .clk (clk), .rst (rst), .bus (c0.slave)
  );
  up_down_counter_mod #(.WIDTH(3), .MAX_VAL(5), .RST_VAL(0)) dut_hi (
    .clk (clk), .rst (rst), .bus (c1.slave)
  );

  assign c1.en = c0.en & c0.at_bound;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int wrap_cnt [7] = '{1, 2, 3, 4, 5, 0, 1};
  int wrap_ovf [7] = '{0, 0, 0, 0, 0, 1, 0};
`ifdef UDC_SAT_EN
  int down_cnt [3] = '{0, 0, 0};
  int down_unf [3] = '{0, 1, 1};
`else
  int down_cnt [3] = '{0, 5, 4};
  int down_unf [3] = '{0, 1, 0};
`endif

  initial begin
    u.en = 1'b0; u.up_down = 1'b1; u.load = 1'b0; u.load_val = 3'd0; u.sat_mode = 1'b0;
    c0.en = 1'b0; c0.up_down = 1'b1; c0.load = 1'b0; c0.load_val = 3'd0; c0.sat_mode = 1'b0;
    c1.up_down = 1'b1; c1.load = 1'b0; c1.load_val = 3'd0; c1.sat_mode = 1'b0;

    // Reset state, and reset overriding a load strobe.
    #2;
    chk("rst_count", 32'(u.count), 0);
    chk("rst_ovf", 32'(u.ovf), 0);
    chk("rst_unf", 32'(u.unf), 0);
    u.load = 1'b1; u.load_val = 3'd4;
    tick();
    chk("rst_over_load", 32'(u.count), 0);
    rst = 1'b0;
    u.load = 1'b0;

    // Reset mid-count: async clear between edges.
    u.load = 1'b1; u.load_val = 3'd3;
    tick();
    u.load = 1'b0;
    chk("pre_rst_count", 32'(u.count), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(u.count), 0);
    chk("async_rst_ovf", 32'(u.ovf), 0);
    chk("async_rst_unf", 32'(u.unf), 0);
    tick();
    rst = 1'b0;

    // Wrap up from 0.
    u.en = 1'b1; u.up_down = 1'b1; u.sat_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("wrap_cnt%0d", i), 32'(u.count), wrap_cnt[i]);
      chk($sformatf("wrap_ovf%0d", i), 32'(u.ovf), wrap_ovf[i]);
      chk($sformatf("wrap_unf%0d", i), 32'(u.unf), 0);
    end

    // Saturate (or wrap) downward from 1.
    u.en = 1'b0; u.load = 1'b1; u.load_val = 3'd1;
    tick();
    chk("load1", 32'(u.count), 1);
    u.load = 1'b0; u.en = 1'b1; u.up_down = 1'b0; u.sat_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("down_cnt%0d", i), 32'(u.count), down_cnt[i]);
      chk($sformatf("down_unf%0d", i), 32'(u.unf), down_unf[i]);
      chk($sformatf("down_ovf%0d", i), 32'(u.ovf), 0);
    end

    // Load priority over enable, with clamp to MAX_VAL.
    u.sat_mode = 1'b0; u.up_down = 1'b1; u.en = 1'b1; u.load = 1'b1; u.load_val = 3'd7;
    tick();
    chk("clamp_cnt", 32'(u.count), 5);
    chk("clamp_ovf", 32'(u.ovf), 0);
    chk("clamp_unf", 32'(u.unf), 0);
    u.load = 1'b0;
    tick();
    chk("post_clamp_cnt", 32'(u.count), 0);
    chk("post_clamp_ovf", 32'(u.ovf), 1);

    // Hold at MAX_VAL and at_bound for both directions.
    u.en = 1'b0; u.load = 1'b1; u.load_val = 3'd5;
    tick();
    u.load = 1'b0;
    tick();
    chk("hold_cnt", 32'(u.count), 5);
    chk("hold_ovf", 32'(u.ovf), 0);
    chk("bound_up", 32'(u.at_bound), 1);
    u.up_down = 1'b0;
    #1;
    chk("bound_down_at5", 32'(u.at_bound), 0);
    u.load = 1'b1; u.load_val = 3'd0;
    tick();
    u.load = 1'b0;
    chk("bound_down_at0", 32'(u.at_bound), 1);

    // Cascade: 20 enabled cycles in radix 6x6.
    rst = 1'b1;
    #3 rst = 1'b0;
    c0.en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    c0.en = 1'b0;
    chk("cascade_lo", 32'(c0.count), 2);
    chk("cascade_hi", 32'(c1.count), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_up_down_counter_mod
